// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per clock; divide-by-zero and signed overflow finish right after the start edge.
`timescale 1ns/1ps
module div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  input  logic [4:0]            rd_addr_in,
  output logic                  busy,
  output logic                  done,
  output logic [4:0]            wr_addr,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] MIN_INT = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] quot;
  logic [DATA_WIDTH:0]   rem_acc;
  logic [DATA_WIDTH-1:0] dvsr;
  logic                  neg_q;
  logic                  neg_r;
  logic                  sel_rem;
  logic [4:0]            rd_q;

  logic                  is_signed;
  logic                  sel_rem_in;
  logic                  a_neg;
  logic                  b_neg;
  logic [DATA_WIDTH-1:0] a_abs;
  logic [DATA_WIDTH-1:0] b_abs;
  logic                  div_zero;
  logic                  overflow;
  logic [DATA_WIDTH-1:0] special_res;

  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH:0]   diff;
  logic                  fits;
  logic [DATA_WIDTH:0]   next_rem;
  logic [DATA_WIDTH-1:0] next_quot;
  logic [DATA_WIDTH-1:0] r_mag;
  logic [DATA_WIDTH-1:0] q_final;
  logic [DATA_WIDTH-1:0] r_final;

  assign busy = (state != IDLE);

  // Operand decode for the start edge; unrecognised funct3 values fall into the DIVU case.
  always_comb begin
    is_signed   = funct3[2] & ~funct3[0];
    sel_rem_in  = funct3[2] & funct3[1];
    a_neg       = is_signed & dividend[DATA_WIDTH-1];
    b_neg       = is_signed & divisor[DATA_WIDTH-1];
    a_abs       = a_neg ? -dividend : dividend;
    b_abs       = b_neg ? -divisor : divisor;
    div_zero    = (divisor == '0);
    overflow    = is_signed && (dividend == MIN_INT) && (divisor == '1);
    special_res = '0;
    if (div_zero)
      special_res = sel_rem_in ? dividend : '1;
    else if (overflow)
      special_res = sel_rem_in ? '0 : MIN_INT;
  end

  // One restoring step; the extra accumulator bit is the borrow that says the divisor did not fit.
  always_comb begin
    shifted   = {rem_acc[DATA_WIDTH-1:0], quot[DATA_WIDTH-1]};
    diff      = shifted - {1'b0, dvsr};
    fits      = ~diff[DATA_WIDTH];
    next_rem  = fits ? diff : shifted;
    next_quot = {quot[DATA_WIDTH-2:0], fits};
    r_mag     = next_rem[DATA_WIDTH-1:0];
    q_final   = neg_q ? -next_quot : next_quot;
    r_final   = neg_r ? -r_mag : r_mag;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      quot    <= '0;
      rem_acc <= '0;
      dvsr    <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      sel_rem <= 1'b0;
      rd_q    <= '0;
      done    <= 1'b0;
      wr_addr <= '0;
      result  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sel_rem <= sel_rem_in;
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
            rd_q    <= rd_addr_in;
            if (div_zero || overflow) begin
              result  <= special_res;
              wr_addr <= rd_addr_in;
              done    <= 1'b1;
              state   <= DONE;
            end else begin
              quot    <= a_abs;
              rem_acc <= '0;
              dvsr    <= b_abs;
              count   <= '0;
              state   <= CALC;
            end
          end
        end
        CALC: begin
          quot    <= next_quot;
          rem_acc <= next_rem;
          count   <= count + 1'b1;
          // Final step feeds the sign-corrected result directly so done lands one cycle later.
          if (count == LAST_STEP) begin
            result  <= sel_rem ? r_final : q_final;
            wr_addr <= rd_q;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, unsigned/signed results,
// special cases, ignored starts and reset abort.
`timescale 1ns/1ps
module tb_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [4:0]  rd_addr_in;
  logic        busy;
  logic        done;
  logic [4:0]  wr_addr;
  logic [31:0] result;

  int n_cmp;
  int n_fail;

  div_unit #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .funct3     (funct3),
    .dividend   (dividend),
    .divisor    (divisor),
    .rd_addr_in (rd_addr_in),
    .busy       (busy),
    .done       (done),
    .wr_addr    (wr_addr),
    .result     (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called 1ns after an edge with the unit idle; returns 1ns after the start edge E0.
  // Operands are scrambled afterwards so any re-sampling would corrupt the result.
  task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
    funct3     = f;
    dividend   = a;
    divisor    = b;
    rd_addr_in = rd;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    dividend   = 32'hDEAD_BEEF;
    divisor    = 32'h0000_0001;
    rd_addr_in = 5'd31;
    funct3     = 3'b100;
  endtask

  // cyc = clock edges after E0 before done is seen (0 for special cases, 32 normally).
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    reset      = 1'b1;
    start      = 1'b0;
    funct3     = 3'b000;
    dividend   = '0;
    divisor    = '0;
    rd_addr_in = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    n_cmp++; if (result !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_result: got %h expected 00000000", result); end
    n_cmp++; if (wr_addr !== 5'd0) begin n_fail++; $display("[TB] FAIL reset_wr_addr: got %0d expected 0", wr_addr); end
    reset = 1'b0;
  endtask

  task automatic test_divu_latency;
    int cyc, busy_cnt, done_cnt, done_at;
    start_op(3'b101, 32'd100, 32'd7, 5'd5);
    cyc = 0; busy_cnt = 0; done_cnt = 0; done_at = -1;
    while (cyc < 200) begin
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = cyc;
        n_cmp++; if (result !== 32'd14) begin n_fail++; $display("[TB] FAIL divu_result: got %h expected 0000000e", result); end
        n_cmp++; if (wr_addr !== 5'd5) begin n_fail++; $display("[TB] FAIL divu_wr_addr: got %0d expected 5", wr_addr); end
      end
      if (busy !== 1'b1) break;
      @(posedge clk);
      #1;
      cyc++;
    end
    n_cmp++; if (done_at !== 32) begin n_fail++; $display("[TB] FAIL divu_done_latency: got %0d expected 32", done_at); end
    n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("[TB] FAIL divu_done_width: got %0d expected 1", done_cnt); end
    n_cmp++; if (busy_cnt !== 33) begin n_fail++; $display("[TB] FAIL divu_busy_cycles: got %0d expected 33", busy_cnt); end
    n_cmp++; if (result !== 32'd14) begin n_fail++; $display("[TB] FAIL divu_result_hold: got %h expected 0000000e", result); end
  endtask

  task automatic test_unsigned;
    logic [2:0]  f_t [5] = '{3'b111, 3'b101, 3'b111, 3'b101, 3'b000};
    logic [31:0] a_t [5] = '{32'd100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFF9};
    logic [31:0] b_t [5] = '{32'd7, 32'd10, 32'd10, 32'd100, 32'd2};
    logic [31:0] e_t [5] = '{32'd2, 32'h1999_9999, 32'd5, 32'd0, 32'h7FFF_FFFC};
    int cyc;
    for (int i = 0; i < 5; i++) begin
      start_op(f_t[i], a_t[i], b_t[i], 5'(i + 10));
      wait_done(cyc);
      n_cmp++; if (cyc !== 32) begin n_fail++; $display("[TB] FAIL unsigned_latency[%0d]: got %0d expected 32", i, cyc); end
      n_cmp++; if (result !== e_t[i]) begin n_fail++; $display("[TB] FAIL unsigned_result[%0d]: got %h expected %h", i, result, e_t[i]); end
      n_cmp++; if (wr_addr !== 5'(i + 10)) begin n_fail++; $display("[TB] FAIL unsigned_wr_addr[%0d]: got %0d expected %0d", i, wr_addr, i + 10); end
      @(posedge clk);
      #1;
      n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL unsigned_return_idle[%0d]: got done=%b busy=%b expected 0 0", i, done, busy); end
    end
  endtask

  task automatic test_signed;
    logic [2:0]  f_t [6] = '{3'b100, 3'b110, 3'b110, 3'b100, 3'b100, 3'b110};
    logic [31:0] a_t [6] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF8};
    logic [31:0] b_t [6] = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd2};
    logic [31:0] e_t [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFD, 32'd3, 32'd0};
    int cyc;
    for (int i = 0; i < 6; i++) begin
      start_op(f_t[i], a_t[i], b_t[i], 5'(i + 1));
      wait_done(cyc);
      n_cmp++; if (cyc !== 32) begin n_fail++; $display("[TB] FAIL signed_latency[%0d]: got %0d expected 32", i, cyc); end
      n_cmp++; if (result !== e_t[i]) begin n_fail++; $display("[TB] FAIL signed_result[%0d]: got %h expected %h", i, result, e_t[i]); end
      n_cmp++; if (wr_addr !== 5'(i + 1)) begin n_fail++; $display("[TB] FAIL signed_wr_addr[%0d]: got %0d expected %0d", i, wr_addr, i + 1); end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_special;
    logic [2:0]  f_t [6] = '{3'b101, 3'b110, 3'b100, 3'b100, 3'b110, 3'b101};
    logic [31:0] a_t [6] = '{32'd5, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] b_t [6] = '{32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] e_t [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'd0};
    int          c_t [6] = '{0, 0, 0, 0, 0, 32};
    int cyc;
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL special_idle_before[%0d]: got busy=%b expected 0", i, busy); end
      start_op(f_t[i], a_t[i], b_t[i], 5'(i + 20));
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL special_busy[%0d]: got %b expected 1", i, busy); end
      wait_done(cyc);
      n_cmp++; if (cyc !== c_t[i]) begin n_fail++; $display("[TB] FAIL special_latency[%0d]: got %0d expected %0d", i, cyc, c_t[i]); end
      n_cmp++; if (result !== e_t[i]) begin n_fail++; $display("[TB] FAIL special_result[%0d]: got %h expected %h", i, result, e_t[i]); end
      n_cmp++; if (wr_addr !== 5'(i + 20)) begin n_fail++; $display("[TB] FAIL special_wr_addr[%0d]: got %0d expected %0d", i, wr_addr, i + 20); end
      @(posedge clk);
      #1;
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL special_done_width[%0d]: got %b expected 0", i, done); end
    end
  endtask

  task automatic test_ignore_start;
    int cyc;
    start_op(3'b101, 32'd100, 32'd7, 5'd5);
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      if (cyc == 5 || cyc == 20) begin
        start      = 1'b1;
        funct3     = 3'b101;
        dividend   = 32'd9;
        divisor    = 32'd3;
        rd_addr_in = 5'd9;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    n_cmp++; if (cyc !== 32) begin n_fail++; $display("[TB] FAIL ignore_latency: got %0d expected 32", cyc); end
    n_cmp++; if (result !== 32'd14) begin n_fail++; $display("[TB] FAIL ignore_result: got %h expected 0000000e", result); end
    n_cmp++; if (wr_addr !== 5'd5) begin n_fail++; $display("[TB] FAIL ignore_wr_addr: got %0d expected 5", wr_addr); end
    @(posedge clk);
    #1;
    start_op(3'b101, 32'd9, 32'd3, 5'd9);
    n_cmp++; if (result !== 32'd14) begin n_fail++; $display("[TB] FAIL back_to_back_hold: got %h expected 0000000e", result); end
    wait_done(cyc);
    n_cmp++; if (cyc !== 32) begin n_fail++; $display("[TB] FAIL back_to_back_latency: got %0d expected 32", cyc); end
    n_cmp++; if (result !== 32'd3) begin n_fail++; $display("[TB] FAIL back_to_back_result: got %h expected 00000003", result); end
    n_cmp++; if (wr_addr !== 5'd9) begin n_fail++; $display("[TB] FAIL back_to_back_wr_addr: got %0d expected 9", wr_addr); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_abort;
    int cyc;
    bit seen;
    start_op(3'b101, 32'd100, 32'd7, 5'd6);
    repeat (10) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL abort_busy_before: got %b expected 1", busy); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_done: got %b expected 0", done); end
    n_cmp++; if (result !== 32'd0) begin n_fail++; $display("[TB] FAIL abort_result: got %h expected 00000000", result); end
    n_cmp++; if (wr_addr !== 5'd0) begin n_fail++; $display("[TB] FAIL abort_wr_addr: got %0d expected 0", wr_addr); end
    seen = 1'b0;
    repeat (40) begin
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      @(posedge clk);
      #1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_no_done: got activity=%b expected 0", seen); end
    start_op(3'b101, 32'd8, 32'd2, 5'd7);
    wait_done(cyc);
    n_cmp++; if (cyc !== 32) begin n_fail++; $display("[TB] FAIL abort_next_latency: got %0d expected 32", cyc); end
    n_cmp++; if (result !== 32'd4) begin n_fail++; $display("[TB] FAIL abort_next_result: got %h expected 00000004", result); end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset;
    test_divu_latency;
    test_unsigned;
    test_signed;
    test_special;
    test_ignore_start;
    test_reset_abort;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
